// File: rtl/bitfusion_top_if.sv
// bitfusion_top_if: operand/result bundle for the Bit Fusion 4x4 multiplier tile.
// The master drives operands and sign modes and receives the registered product.
interface bitfusion_top_if;
    logic [3:0] in;
    logic [3:0] weight;
    logic       s_in;
    logic       s_weight;
    logic [7:0] psum;

    modport master (
        output in,
        output weight,
        output s_in,
        output s_weight,
        input  psum
    );

    modport slave (
        input  in,
        input  weight,
        input  s_in,
        input  s_weight,
        output psum
    );
endinterface

// File: rtl/bitfusion_top.sv
// bitfusion_top: 4-bit x 4-bit multiplier built from four 2x2 BitBricks whose
// shifted partial products are fused into one registered 8-bit result.
// Each operand is signed or unsigned under control of its own sign bit.
// Optional macro BITFUSION_INREG_EN adds an input register stage (2-cycle latency).
module bitfusion_top (
    input  logic                  CLK_125MHZ_FPGA,
    input  logic                  rst,
    bitfusion_top_if.slave        bus
);

    logic [3:0]        w_inOp;
    logic [3:0]        w_weightOp;
    logic              w_sIn;
    logic              w_sWeight;

    logic signed [2:0] w_ih;
    logic signed [2:0] w_il;
    logic signed [2:0] w_wh;
    logic signed [2:0] w_wl;

    logic signed [5:0] w_pHh;
    logic signed [5:0] w_pHl;
    logic signed [5:0] w_pLh;
    logic signed [5:0] w_pLl;

    logic [9:0]        w_termHh;
    logic [9:0]        w_termHl;
    logic [9:0]        w_termLh;
    logic [9:0]        w_termLl;
    logic [9:0]        w_sum;
    logic [1:0]        w_unusedSumTop;

    logic [7:0]        r_psum;

    // One BitBrick: 3x3 signed multiply, both operands widened to the 6-bit result first
    function automatic logic signed [5:0] brickMul(input logic signed [2:0] a,
                                                   input logic signed [2:0] b);
        logic signed [5:0] ea;
        logic signed [5:0] eb;
        ea = {{3{a[2]}}, a};
        eb = {{3{b[2]}}, b};
        return ea * eb;
    endfunction

`ifdef BITFUSION_INREG_EN
    logic [3:0] r_in;
    logic [3:0] r_weight;
    logic       r_sIn;
    logic       r_sWeight;

    // Capture operands and sign modes together so a mode change stays aligned with its data
    always_ff @(posedge CLK_125MHZ_FPGA) begin
        if (rst) begin
            r_in      <= 4'h0;
            r_weight  <= 4'h0;
            r_sIn     <= 1'b0;
            r_sWeight <= 1'b0;
        end else begin
            r_in      <= bus.in;
            r_weight  <= bus.weight;
            r_sIn     <= bus.s_in;
            r_sWeight <= bus.s_weight;
        end
    end

    assign w_inOp     = r_in;
    assign w_weightOp = r_weight;
    assign w_sIn      = r_sIn;
    assign w_sWeight  = r_sWeight;
`else
    assign w_inOp     = bus.in;
    assign w_weightOp = bus.weight;
    assign w_sIn      = bus.s_in;
    assign w_sWeight  = bus.s_weight;
`endif

    // High halves carry the operand sign only in signed mode; low halves are always magnitudes
    assign w_ih = {w_sIn & w_inOp[3], w_inOp[3:2]};
    assign w_il = {1'b0, w_inOp[1:0]};
    assign w_wh = {w_sWeight & w_weightOp[3], w_weightOp[3:2]};
    assign w_wl = {1'b0, w_weightOp[1:0]};

    assign w_pHh = brickMul(w_ih, w_wh);
    assign w_pHl = brickMul(w_ih, w_wl);
    assign w_pLh = brickMul(w_il, w_wh);
    assign w_pLl = brickMul(w_il, w_wl);

    // Fusion: sign-extend each brick product to 10 bits at its binary weight and add
    assign w_termHh = {w_pHh, 4'b0000};
    assign w_termHl = {{2{w_pHl[5]}}, w_pHl, 2'b00};
    assign w_termLh = {{2{w_pLh[5]}}, w_pLh, 2'b00};
    assign w_termLl = {{4{w_pLl[5]}}, w_pLl};
    assign w_sum    = w_termHh + w_termHl + w_termLh + w_termLl;

    // Only the low byte is the product; the two guard bits are intentionally dropped
    assign w_unusedSumTop = w_sum[9:8];

    // Output register: reset wins over new data
    always_ff @(posedge CLK_125MHZ_FPGA) begin
        if (rst) begin
            r_psum <= 8'h00;
        end else begin
            r_psum <= w_sum[7:0];
        end
    end

    assign bus.psum = r_psum;

endmodule

// File: tb/tb_bitfusion_top.sv
// tb_bitfusion_top: directed and swept stimulus for bitfusion_top with a
// queue scoreboard; latency follows BITFUSION_INREG_EN.
module tb_bitfusion_top;

`ifdef BITFUSION_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] expected;
        string      tag;
    } scoreEntry_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    scoreEntry_t scoreQ[$];

    bitfusion_top_if busIf ();

    bitfusion_top dut (
        .CLK_125MHZ_FPGA (clk),
        .rst             (rst),
        .bus             (busIf.slave)
    );

    // 125 MHz clock
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // Reference product: interpret each operand per its sign bit, keep low byte
    function automatic logic [7:0] refProduct(input logic [3:0] a, input logic [3:0] b,
                                              input logic sa, input logic sb);
        int av;
        int bv;
        int p;
        av = (sa && a[3]) ? int'(a) - 16 : int'(a);
        bv = (sb && b[3]) ? int'(b) - 16 : int'(b);
        p  = av * bv;
        return p[7:0];
    endfunction

    // Compare the oldest pending expectation against the DUT output
    task automatic checkOutput();
        scoreEntry_t e;
        logic [7:0]  observed;
        e        = scoreQ.pop_front();
        observed = busIf.psum;
        checks++;
        assert (observed === e.expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.expected);
        end
    endtask

    // Drive one cycle of inputs, push its expectation, clock, then check what has matured
    task automatic applyStimulus(input logic r, input logic [3:0] a, input logic [3:0] b,
                                 input logic sa, input logic sb,
                                 input logic [7:0] expected, input string tag);
        scoreEntry_t e;
        rst             = r;
        busIf.in        = a;
        busIf.weight    = b;
        busIf.s_in      = sa;
        busIf.s_weight  = sb;
        e.expected      = expected;
        e.tag           = tag;
        scoreQ.push_back(e);
        @(posedge clk);
        #1;
        if (scoreQ.size() >= LAT) checkOutput();
    endtask

    // Directed sequence
    initial begin
        logic [3:0] a;
        logic [3:0] b;
        checks   = 0;
        failures = 0;

        // Reset held two cycles with all-ones operands
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 8'h00, "reset0");
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 8'h00, "reset1");
        applyStimulus(1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 8'hE1, "postReset15x15");

        // Unsigned spot values
        applyStimulus(1'b0, 4'h7, 4'h9, 1'b0, 1'b0, 8'h3F, "u7x9");
        applyStimulus(1'b0, 4'h0, 4'hD, 1'b0, 1'b0, 8'h00, "u0xN");
        applyStimulus(1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 8'hE1, "u15x15");

        // Unsigned sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = 4'(i);
                b = 4'(j);
                applyStimulus(1'b0, a, b, 1'b0, 1'b0, refProduct(a, b, 1'b0, 1'b0),
                              $sformatf("uSweep_%0d_%0d", i, j));
            end
        end

        // Signed spot values
        applyStimulus(1'b0, 4'h8, 4'h8, 1'b1, 1'b1, 8'h40, "sM8xM8");
        applyStimulus(1'b0, 4'h8, 4'h7, 1'b1, 1'b1, 8'hC8, "sM8x7");
        applyStimulus(1'b0, 4'hF, 4'h1, 1'b1, 1'b1, 8'hFF, "sM1x1");
        applyStimulus(1'b0, 4'h7, 4'h7, 1'b1, 1'b1, 8'h31, "s7x7");

        // Signed sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = 4'(i);
                b = 4'(j);
                applyStimulus(1'b0, a, b, 1'b1, 1'b1, refProduct(a, b, 1'b1, 1'b1),
                              $sformatf("sSweep_%0d_%0d", i, j));
            end
        end

        // Mixed modes
        applyStimulus(1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 8'hF1, "mixSignedIn");
        applyStimulus(1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 8'hF1, "mixSignedWeight");
        applyStimulus(1'b0, 4'h8, 4'h3, 1'b1, 1'b0, 8'hE8, "mixM8x3");

        // Back-to-back mode switches, no stale results
        applyStimulus(1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 8'h40, "b2bU8x8");
        applyStimulus(1'b0, 4'h8, 4'h8, 1'b1, 1'b1, 8'h40, "b2bS8x8");
        applyStimulus(1'b0, 4'hF, 4'hE, 1'b1, 1'b1, 8'h02, "b2bSM1xM2");
        applyStimulus(1'b0, 4'hF, 4'hE, 1'b0, 1'b0, 8'hD2, "b2bU15x14");
        applyStimulus(1'b0, 4'hC, 4'h5, 1'b1, 1'b0, 8'hEC, "b2bMixM4x5");

        // Reset in mid-stream takes priority over live operands
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 8'h00, "midReset");
        applyStimulus(1'b0, 4'h3, 4'h5, 1'b0, 1'b0, 8'h0F, "afterMidReset");

        // Drain remaining expectations
        while (scoreQ.size() > 0) begin
            @(posedge clk);
            #1;
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
